trng_seq_ctrl: RTL and testbench

TRNG_SEQ_CTRL -- requirements
Module: trng_seq_ctrl

---
 rtl/trng_seq_ctrl.sv | 102 ++++++++++
 tb/tb_trng_seq_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/trng_seq_ctrl.sv
// trng_seq_ctrl: sequencer feeding a skewed row stream into a triangular systolic array.
// Optional perf counters (row_cnt, cyc_cnt) are built when TRNG_SEQ_CTRL_PERF_EN is defined.
module trng_seq_ctrl #(
    parameter int N_DIM = 3,
    parameter int DW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_DIM*DW-1:0]   in_data,
    input  logic                  in_last,
    output logic                  arr_clr,
    output logic                  arr_en,
    output logic [1:0]            arr_mode,
    output logic [N_DIM*DW-1:0]   arr_vin,
    output logic [N_DIM-1:0]      arr_vin_vld,
    input  logic                  out_ready
`ifdef TRNG_SEQ_CTRL_PERF_EN
    ,
    output logic [15:0]           row_cnt,
    output logic [31:0]           cyc_cnt
`endif
);
    localparam int CW = $clog2(2 * N_DIM);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, FLUSH, DRAIN, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic acc, shifting;
    assign acc      = in_valid && in_ready;
    assign shifting = (state == LOAD) || (state == FLUSH);
    // cnt is reused: FLUSH length first, then remaining DRAIN beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE:  if (start) state <= CLEAR;
                CLEAR: state <= LOAD;
                LOAD:  if (in_valid && in_last) begin
                    state <= FLUSH;
                    cnt   <= CW'(2 * N_DIM - 2);
                end
                FLUSH: if (cnt == '0) begin
                    state <= DRAIN;
                    cnt   <= CW'(N_DIM - 1);
                end else cnt <= cnt - 1'b1;
                DRAIN: if (out_ready) begin
                    if (cnt == '0) state <= DONE;
                    else cnt <= cnt - 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign in_ready = state == LOAD;
    assign arr_clr  = state == CLEAR;
    assign arr_en   = shifting || (state == DRAIN && out_ready);
    assign arr_mode = shifting ? 2'b01 : (state == DRAIN) ? 2'b10 : 2'b00;
    // lane k is delayed through k+1 stages; idle slots carry zero bubbles
    for (genvar k = 0; k < N_DIM; k++) begin : g_lane
        logic [DW-1:0] d [k+1];
        logic [k:0]    v;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= k; j++) d[j] <= '0;
                v <= '0;
            end else if (shifting) begin
                d[0] <= acc ? in_data[k*DW +: DW] : '0;
                v[0] <= acc;
                for (int j = k; j > 0; j--) begin
                    d[j] <= d[j-1];
                    v[j] <= v[j-1];
                end
            end
        end
        assign arr_vin[k*DW +: DW] = shifting ? d[k] : '0;
        assign arr_vin_vld[k]      = shifting && v[k];
    end
`ifdef TRNG_SEQ_CTRL_PERF_EN
    // counters restart on job start and freeze once DONE is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt <= '0;
            cyc_cnt <= '0;
        end else if (state == IDLE && start) begin
            row_cnt <= '0;
            cyc_cnt <= '0;
        end else if (busy && state != DONE) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (acc && row_cnt != 16'hFFFF) row_cnt <= row_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_trng_seq_ctrl.sv
// tb_trng_seq_ctrl: table-driven check of trng_seq_ctrl (N_DIM=3, DW=16) plus reset and perf sequences.
module tb_trng_seq_ctrl;
    logic clk = 0, rst = 1, start = 0, in_valid = 0, in_last = 0, out_ready = 0;
    logic [47:0] in_data = '0;
    logic busy, done, in_ready, arr_clr, arr_en;
    logic [1:0] arr_mode;
    logic [47:0] arr_vin;
    logic [2:0] arr_vin_vld;
`ifdef TRNG_SEQ_CTRL_PERF_EN
    logic [15:0] row_cnt;
    logic [31:0] cyc_cnt;
`endif
    int n_tests = 0, n_fail = 0;

    trng_seq_ctrl #(.N_DIM(3), .DW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .arr_clr(arr_clr), .arr_en(arr_en), .arr_mode(arr_mode),
        .arr_vin(arr_vin), .arr_vin_vld(arr_vin_vld), .out_ready(out_ready)
`ifdef TRNG_SEQ_CTRL_PERF_EN
        , .row_cnt(row_cnt), .cyc_cnt(cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [47:0] R1 = 48'h0013_0012_0011;
    localparam logic [47:0] R2 = 48'h0023_0022_0021;
    localparam logic [47:0] R3 = 48'h0033_0032_0031;

    typedef struct packed {
        logic st, iv, il, ordy;
        logic [47:0] din;
        logic [3:0] fl;
        logic [1:0] mode;
        logic [2:0] vld;
        logic [47:0] vin;
        logic dn;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic st, iv, il, ordy, input logic [47:0] din,
                                input logic [3:0] fl, input logic [1:0] mode,
                                input logic [2:0] vld, input logic [47:0] vin, input logic dn);
        vec_t t;
        t.st = st; t.iv = iv; t.il = il; t.ordy = ordy; t.din = din;
        t.fl = fl; t.mode = mode; t.vld = vld; t.vin = vin; t.dn = dn;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic logic [9:0] ctl();
        return {busy, in_ready, arr_clr, arr_en, arr_mode, arr_vin_vld, done};
    endfunction

    task automatic drive(input logic st, iv, il, ordy, input logic [47:0] din);
        start = st; in_valid = iv; in_last = il; out_ready = ordy; in_data = din;
    endtask

    initial begin
        int done_at;
        // continuous load: rows back-to-back, last on row 3
        tbl.push_back(mk(1,0,0,1,0,  4'b0000,0,3'b000,48'h0,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1010,0,3'b000,48'h0,0));
        tbl.push_back(mk(0,1,0,1,R1, 4'b1101,1,3'b000,48'h0,0));
        tbl.push_back(mk(0,1,0,1,R2, 4'b1101,1,3'b001,48'h0000_0000_0011,0));
        tbl.push_back(mk(0,1,1,1,R3, 4'b1101,1,3'b011,48'h0000_0012_0021,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,1,3'b111,48'h0013_0022_0031,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,1,3'b110,48'h0023_0032_0000,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,1,3'b100,48'h0033_0000_0000,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,1,3'b000,48'h0,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,1,3'b000,48'h0,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,2,3'b000,48'h0,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,2,3'b000,48'h0,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,2,3'b000,48'h0,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1000,0,3'b000,48'h0,1));
        tbl.push_back(mk(0,0,0,1,0,  4'b0000,0,3'b000,48'h0,0));
        // bubble between rows, ignored start/in_last, drain stall, start during DONE
        tbl.push_back(mk(1,0,0,1,0,  4'b0000,0,3'b000,48'h0,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1010,0,3'b000,48'h0,0));
        tbl.push_back(mk(0,1,0,1,R1, 4'b1101,1,3'b000,48'h0,0));
        tbl.push_back(mk(1,0,1,1,R2, 4'b1101,1,3'b001,48'h0000_0000_0011,0));
        tbl.push_back(mk(0,1,1,1,R2, 4'b1101,1,3'b010,48'h0000_0012_0000,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,1,3'b101,48'h0013_0000_0021,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,1,3'b010,48'h0000_0022_0000,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,1,3'b100,48'h0023_0000_0000,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,1,3'b000,48'h0,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,1,3'b000,48'h0,0));
        tbl.push_back(mk(1,0,0,1,0,  4'b1001,2,3'b000,48'h0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,0,0,0, 4'b1000,2,3'b000,48'h0,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,2,3'b000,48'h0,0));
        tbl.push_back(mk(0,0,0,1,0,  4'b1001,2,3'b000,48'h0,0));
        tbl.push_back(mk(1,0,0,1,0,  4'b1000,0,3'b000,48'h0,1));
        tbl.push_back(mk(0,0,0,1,0,  4'b0000,0,3'b000,48'h0,0));

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctl", 64'(ctl()), 64'h0);
        chk("reset vin", 64'(arr_vin), 64'h0);
        rst = 0;
        #1;
        chk("post-reset ctl", 64'(ctl()), 64'h0);

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].iv, tbl[i].il, tbl[i].ordy, tbl[i].din);
            #3;
            chk($sformatf("vec%0d ctl", i), 64'(ctl()),
                64'({tbl[i].fl, tbl[i].mode, tbl[i].vld, tbl[i].dn}));
            chk($sformatf("vec%0d vin", i), 64'(arr_vin), 64'(tbl[i].vin));
            @(posedge clk);
            #1;
        end

        // asynchronous reset in FLUSH
        drive(1,0,0,1,0); @(posedge clk); #1;
        drive(0,0,0,1,0); @(posedge clk); #1;
        drive(0,1,1,1,R1); @(posedge clk); #1;
        drive(0,0,0,1,0); @(posedge clk); #1;
        chk("in flush mode", 64'(arr_mode), 64'h1);
        #2 rst = 1;
        #1;
        chk("async rst ctl", 64'(ctl()), 64'h0);
        chk("async rst vin", 64'(arr_vin), 64'h0);
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("after rst ctl", 64'(ctl()), 64'h0);

        // clean job after reset: single row, expect done 11 cycles after start
        done_at = -1;
        for (int n = 0; n < 30 && done_at < 0; n++) begin
            drive(n == 0, n == 2, 1, 1, R3);
            #3;
            if (n == 3) begin
                chk("clean lane0 vld", 64'(arr_vin_vld), 64'h1);
                chk("clean lane0 data", 64'(arr_vin[15:0]), 64'h0031);
            end
            if (n == 5) chk("clean lane2", 64'({arr_vin_vld, arr_vin[47:32]}), 64'h4_0033);
            if (done) done_at = n;
            @(posedge clk);
            #1;
        end
        chk("clean done cycle", 64'(done_at), 64'd11);
        drive(0,0,0,1,0);

`ifdef TRNG_SEQ_CTRL_PERF_EN
        begin
            int meas;
            meas = 0;
            done_at = -1;
            for (int n = 0; n < 40 && done_at < 0; n++) begin
                drive(n == 0, n >= 2 && n <= 6, n == 6, 1, R1);
                #3;
                if (done) begin
                    done_at = n;
                    chk("perf row_cnt", 64'(row_cnt), 64'd5);
                    chk("perf cyc_cnt", 64'(cyc_cnt), 64'(meas));
                end else if (busy) meas++;
                @(posedge clk);
                #1;
            end
            chk("perf busy cycles", 64'(meas), 64'd14);
            drive(0,0,0,1,0);
            repeat (2) @(posedge clk);
            #1;
            chk("perf hold", 64'({row_cnt, cyc_cnt}), 64'({16'd5, 32'd14}));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
